// File: rtl/ddr2_tg_pkg.sv
// Shared types and constants for the DDR2 traffic generator: FSM states,
// pass modes, pattern seed and the Galois LFSR step used by the PRBS build.
package ddr2_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_GAP,
    ST_WR_REQ,
    ST_WR_XFER,
    ST_RD_GAP,
    ST_RD_REQ,
    ST_RD_XFER,
    ST_DONE
  } tg_state_e;

  localparam logic TG_MODE_WR   = 1'b0;
  localparam logic TG_MODE_WRRD = 1'b1;

  localparam logic [31:0] TG_SEED      = 32'h0000_0001;
  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] TG_LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TG_LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/ddr2_tg_pattern.sv
// Deterministic data pattern source: incrementing counter by default, 32-bit
// Galois LFSR replicated to DATA_WIDTH when DDR2_TG_PRBS_EN is defined.
module ddr2_tg_pattern
  import ddr2_tg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_adv,
  output logic [DATA_WIDTH-1:0] o_word
);

`ifdef DDR2_TG_PRBS_EN
  logic [31:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_lfsr <= TG_SEED;
    else if (i_load) r_lfsr <= TG_SEED;
    else if (i_adv)  r_lfsr <= lfsr_step(r_lfsr);
  end

  always_comb begin
    o_word = '0;
    for (int i = 0; i < DATA_WIDTH; i++) o_word[i] = r_lfsr[i % 32];
  end
`else
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  logic [DATA_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= DATA_WIDTH'(TG_SEED);
    else if (i_load) r_cnt <= DATA_WIDTH'(TG_SEED);
    else if (i_adv)  r_cnt <= r_cnt + ONE;
  end

  assign o_word = r_cnt;
`endif

endmodule

// File: rtl/ddr2_traffic_gen.sv
// DDR2 user-port traffic generator/checker: writes NUM_BURSTS bursts, optionally
// reads them back and counts mismatches. Pattern selected by DDR2_TG_PRBS_EN.
module ddr2_traffic_gen
  import ddr2_tg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BURST_LEN  = 16,
  parameter int                    NUM_BURSTS = 4,
  parameter int                    GAP_CYCLES = 80,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_init_end,
  input  logic                  i_start,
  input  logic                  i_mode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [15:0]           o_err_cnt,
  output logic                  o_wr_trig,
  output logic [7:0]            o_wr_len,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic                  i_wr_ready,
  input  logic                  i_wr_data_en,
  input  logic                  i_wr_done,
  output logic                  o_rd_trig,
  output logic [7:0]            o_rd_len,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic                  i_rd_ready,
  input  logic                  i_rd_data_en,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(2 * BURST_LEN);
  localparam logic [31:0]           GAP_LAST    = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [15:0]           BEATS       = 16'(BURST_LEN);
  localparam logic [15:0]           BURSTS_LAST = 16'(NUM_BURSTS - 1);

  tg_state_e             r_state, w_next;
  logic                  r_mode;
  logic [31:0]           r_gap_cnt;
  logic [15:0]           r_burst_cnt, r_beat_cnt, w_beats;
  logic                  w_accept, w_wr_beat, w_rd_beat, w_wr_end, w_rd_end;
  logic                  w_last_burst, w_mismatch, w_len_err, w_in_gap;
  logic [1:0]            w_err_inc;
  logic [16:0]           w_err_sum;
  logic                  w_rd_load;
  logic [DATA_WIDTH-1:0] w_exp_word;

  assign w_accept     = (r_state == ST_IDLE) && i_start && i_init_end;
  assign w_wr_beat    = (r_state == ST_WR_XFER) && i_wr_data_en;
  assign w_rd_beat    = (r_state == ST_RD_XFER) && i_rd_data_en;
  assign w_wr_end     = (r_state == ST_WR_XFER) && i_wr_done;
  assign w_rd_end     = (r_state == ST_RD_XFER) && i_rd_done;
  assign w_in_gap     = (r_state == ST_WR_GAP) || (r_state == ST_RD_GAP);
  assign w_last_burst = (r_burst_cnt == BURSTS_LAST);
  // A beat arriving together with done still belongs to the burst being closed
  assign w_beats      = r_beat_cnt + 16'(w_wr_beat | w_rd_beat);
  assign w_len_err    = (w_wr_end | w_rd_end) && (w_beats != BEATS);
  assign w_mismatch   = w_rd_beat && (i_rd_data != w_exp_word);
  assign w_err_inc    = {1'b0, w_mismatch} + {1'b0, w_len_err};
  assign w_err_sum    = {1'b0, o_err_cnt} + {15'b0, w_err_inc};
  assign w_rd_load    = w_accept || (w_wr_end && w_last_burst);

  assign o_wr_len = 8'(BURST_LEN);
  assign o_rd_len = 8'(BURST_LEN);

  ddr2_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_adv  (w_wr_beat),
    .o_word (o_wr_data)
  );

  ddr2_tg_pattern #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_rd_load),
    .i_adv  (w_rd_beat),
    .o_word (w_exp_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_WR_GAP;
      ST_WR_GAP:  if (r_gap_cnt == GAP_LAST) w_next = ST_WR_REQ;
      ST_WR_REQ:  if (o_wr_trig && i_wr_ready) w_next = ST_WR_XFER;
      ST_WR_XFER: if (i_wr_done) begin
                    if (!w_last_burst)              w_next = ST_WR_GAP;
                    else if (r_mode == TG_MODE_WRRD) w_next = ST_RD_GAP;
                    else                            w_next = ST_DONE;
                  end
      ST_RD_GAP:  if (r_gap_cnt == GAP_LAST) w_next = ST_RD_REQ;
      ST_RD_REQ:  if (o_rd_trig && i_rd_ready) w_next = ST_RD_XFER;
      ST_RD_XFER: if (i_rd_done) w_next = w_last_burst ? ST_DONE : ST_RD_GAP;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= TG_MODE_WR;
      r_gap_cnt   <= '0;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_cnt   <= '0;
      o_wr_trig   <= 1'b0;
      o_rd_trig   <= 1'b0;
      o_wr_addr   <= BASE_ADDR;
      o_rd_addr   <= BASE_ADDR;
    end else begin
      r_state   <= w_next;
      o_busy    <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      o_done    <= (w_next == ST_DONE);
      o_wr_trig <= (w_next == ST_WR_REQ);
      o_rd_trig <= (w_next == ST_RD_REQ);
      r_gap_cnt <= (w_in_gap && (w_next == r_state)) ? r_gap_cnt + 32'd1 : 32'd0;
      if (w_accept) begin
        r_mode      <= i_mode;
        o_err_cnt   <= '0;
        o_pass      <= 1'b0;
        r_burst_cnt <= '0;
        r_beat_cnt  <= '0;
        o_wr_addr   <= BASE_ADDR;
        o_rd_addr   <= BASE_ADDR;
      end else begin
        if (w_wr_end || w_rd_end)        r_beat_cnt <= '0;
        else if (w_wr_beat || w_rd_beat) r_beat_cnt <= r_beat_cnt + 16'd1;
        if (w_wr_end) begin
          o_wr_addr <= o_wr_addr + ADDR_STEP;
          if (w_last_burst) begin
            r_burst_cnt <= '0;
            o_rd_addr   <= BASE_ADDR;
          end else begin
            r_burst_cnt <= r_burst_cnt + 16'd1;
          end
        end
        if (w_rd_end) begin
          o_rd_addr   <= o_rd_addr + ADDR_STEP;
          r_burst_cnt <= w_last_burst ? 16'd0 : r_burst_cnt + 16'd1;
        end
        o_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        if (r_state == ST_DONE) o_pass <= (r_mode == TG_MODE_WRRD) && (o_err_cnt == 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Randomized self-checking bench for ddr2_traffic_gen with a behavioural
// memory/pattern model; a second instance exercises address wrap-around.
`timescale 1ns/1ps
module tb_ddr2_traffic_gen;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int BL  = 16;
  localparam int NB  = 4;
  localparam int GAP = 80;
  localparam logic [AW-1:0] BASE2 = 26'h3FF_FFE0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          init_end, start, mode;
  logic          wr_ready, wr_data_en, wr_done, rd_ready, rd_data_en, rd_done;
  logic [DW-1:0] rd_data;
  logic          busy, done, pass, wr_trig, rd_trig;
  logic [15:0]   err_cnt;
  logic [7:0]    wr_len, rd_len;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic          u2Start, u2Ready, u2DataEn, u2Done;
  logic          u2Busy, u2DoneOut, u2Pass, u2WrTrig, u2RdTrig;
  logic [15:0]   u2Err;
  logic [7:0]    u2WrLen, u2RdLen;
  logic [AW-1:0] u2WrAddr, u2RdAddr;
  logic [DW-1:0] u2WrData;

  ddr2_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB),
    .GAP_CYCLES(GAP), .BASE_ADDR('0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_init_end(init_end), .i_start(start), .i_mode(mode),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
    .o_wr_trig(wr_trig), .o_wr_len(wr_len), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_wr_ready(wr_ready), .i_wr_data_en(wr_data_en), .i_wr_done(wr_done),
    .o_rd_trig(rd_trig), .o_rd_len(rd_len), .o_rd_addr(rd_addr),
    .i_rd_ready(rd_ready), .i_rd_data_en(rd_data_en), .i_rd_data(rd_data), .i_rd_done(rd_done)
  );

  ddr2_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(2),
    .GAP_CYCLES(2), .BASE_ADDR(BASE2)
  ) dutWrap (
    .clk(clk), .rst_n(rst_n), .i_init_end(1'b1), .i_start(u2Start), .i_mode(1'b0),
    .o_busy(u2Busy), .o_done(u2DoneOut), .o_pass(u2Pass), .o_err_cnt(u2Err),
    .o_wr_trig(u2WrTrig), .o_wr_len(u2WrLen), .o_wr_addr(u2WrAddr), .o_wr_data(u2WrData),
    .i_wr_ready(u2Ready), .i_wr_data_en(u2DataEn), .i_wr_done(u2Done),
    .o_rd_trig(u2RdTrig), .o_rd_len(u2RdLen), .o_rd_addr(u2RdAddr),
    .i_rd_ready(1'b0), .i_rd_data_en(1'b0), .i_rd_data('0), .i_rd_done(1'b0)
  );

  int vecCount  = 0;
  int missCount = 0;
  logic [DW-1:0] mem [int];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // n-th word of a pass (1-based) from the pattern definition
  function automatic logic [DW-1:0] expWord(input int n);
`ifdef DDR2_TG_PRBS_EN
    logic [31:0] s = 32'h1;
    for (int i = 1; i < n; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
`else
    return DW'(n);
`endif
  endfunction

  function automatic logic [AW-1:0] expAddr(input logic [AW-1:0] base, input int b);
    return AW'(longint'(base) + longint'(b) * 2 * BL);
  endfunction

  task automatic waitHigh(input string tag, input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((which == 0 && wr_trig) || (which == 1 && rd_trig) || (which == 2 && done)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(tag, ok, 1'b1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_pass"}, pass, 0);
    checkOutput({tag, "_err"}, err_cnt, 0);
    checkOutput({tag, "_wtrig"}, wr_trig, 0);
    checkOutput({tag, "_rtrig"}, rd_trig, 0);
    checkOutput({tag, "_waddr"}, wr_addr, 0);
    checkOutput({tag, "_raddr"}, rd_addr, 0);
    checkOutput({tag, "_wdata"}, wr_data, expWord(1));
    checkOutput({tag, "_wlen"}, wr_len, BL);
    checkOutput({tag, "_rlen"}, rd_len, BL);
  endtask

  task automatic applyStimulus(input logic m, input int fixedFlip, input int nRandFlips,
                               input int holdCycles, input int abortBurst);
    int flipSet[int];
    int beatNo, cyc, hold, hi, expErr;
    bit ok, together;
    if (fixedFlip >= 0) flipSet[fixedFlip] = 1;
    for (int f = 0; f < nRandFlips; f++) flipSet[$urandom_range(NB * BL - 1)] = 1;
    expErr = m ? flipSet.num() : 0;

    @(negedge clk);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    checkOutput("busy_rise", busy, 1);
    cyc = 1;
    while (!wr_trig && cyc < GAP + 200) begin @(negedge clk); cyc++; end
    checkOutput("first_trig_latency", cyc, GAP + 1);

    beatNo = 0;
    for (int b = 0; b < NB; b++) begin
      if (b > 0) begin
        waitHigh("wr_trig_wait", 0, GAP + 100, ok);
        if (!ok) return;
      end
      hold = (b == 0 && holdCycles > 0) ? holdCycles : $urandom_range(0, 3);
      hi = 0;
      for (int i = 0; i < hold; i++) begin hi += int'(wr_trig); @(negedge clk); end
      if (b == 0 && holdCycles > 0) checkOutput("wr_trig_held", hi, hold);
      checkOutput("wr_addr", wr_addr, expAddr('0, b));
      wr_ready = 1'b1;
      @(negedge clk);
      wr_ready = 1'b0;
      checkOutput("wr_trig_drop", wr_trig, 0);
      together = 1'b0;
      for (int k = 0; k < BL; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (b == abortBurst && k == 5) begin
          #2 rst_n = 1'b0;
          #1 checkResetValues("async_rst");
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        checkOutput("wr_data", wr_data, expWord(beatNo + 1));
        mem[b * BL + k] = wr_data;
        wr_data_en = 1'b1;
        if (k == BL - 1) begin
          together = 1'($urandom_range(0, 1));
          wr_done = together;
        end
        @(negedge clk);
        wr_data_en = 1'b0; wr_done = 1'b0;
        beatNo++;
      end
      if (!together) begin wr_done = 1'b1; @(negedge clk); wr_done = 1'b0; end
    end

    if (m) begin
      for (int b = 0; b < NB; b++) begin
        waitHigh("rd_trig_wait", 1, GAP + 100, ok);
        if (!ok) return;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checkOutput("rd_addr", rd_addr, expAddr('0, b));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        checkOutput("rd_trig_drop", rd_trig, 0);
        for (int k = 0; k < BL; k++) begin
          repeat ($urandom_range(0, 2)) begin rd_data = DW'($urandom); @(negedge clk); end
          rd_data = mem[b * BL + k] ^ (flipSet.exists(b * BL + k) ? DW'(1) : DW'(0));
          rd_data_en = 1'b1;
          @(negedge clk);
          rd_data_en = 1'b0;
          rd_data = DW'($urandom);
        end
        rd_done = 1'b1; @(negedge clk); rd_done = 1'b0;
      end
    end

    waitHigh("done_wait", 2, 50, ok);
    if (!ok) return;
    checkOutput("busy_with_done", busy, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("err_cnt", err_cnt, expErr);
    checkOutput("pass", pass, (m && expErr == 0) ? 1 : 0);
  endtask

  task automatic wrapCheck;
    bit ok;
    int cyc;
    checkOutput("wrap_reset_addr", u2WrAddr, BASE2);
    @(negedge clk); u2Start = 1'b1;
    @(negedge clk); u2Start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      cyc = 0;
      while (!u2WrTrig && cyc < 50) begin @(negedge clk); cyc++; end
      checkOutput("wrap_trig_wait", u2WrTrig, 1);
      checkOutput("wrap_addr", u2WrAddr, expAddr(BASE2, b));
      u2Ready = 1'b1; @(negedge clk); u2Ready = 1'b0;
      for (int k = 0; k < BL; k++) begin
        checkOutput("wrap_data", u2WrData, expWord(b * BL + k + 1));
        u2DataEn = 1'b1; u2Done = (k == BL - 1);
        @(negedge clk);
        u2DataEn = 1'b0; u2Done = 1'b0;
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin ok = u2DoneOut; if (!ok) @(negedge clk); end
    checkOutput("wrap_done", ok, 1'b1);
    @(negedge clk);
    checkOutput("wrap_err", u2Err, 0);
    checkOutput("wrap_pass", u2Pass, 0);
  endtask

  initial begin
    init_end = 1'b0; start = 1'b0; mode = 1'b0;
    wr_ready = 1'b0; wr_data_en = 1'b0; wr_done = 1'b0;
    rd_ready = 1'b0; rd_data_en = 1'b0; rd_done = 1'b0; rd_data = '0;
    u2Start = 1'b0; u2Ready = 1'b0; u2DataEn = 1'b0; u2Done = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1; init_end = 1'b1;
    @(negedge clk);

    $display("[TB] write-only pass");
    applyStimulus(1'b0, -1, 0, 0, -1);
    $display("[TB] write/read pass, clean memory");
    applyStimulus(1'b1, -1, 0, 0, -1);
    $display("[TB] write/read pass, one corrupted beat");
    applyStimulus(1'b1, 2 * BL + 5, 0, 0, -1);
    $display("[TB] write-only pass with long ready stall");
    applyStimulus(1'b0, -1, 0, 200, -1);
    $display("[TB] reset during third burst");
    applyStimulus(1'b0, -1, 0, 0, 2);
    init_end = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("start_no_init_busy", busy, 0);
    checkOutput("start_no_init_trig", wr_trig, 0);
    init_end = 1'b1;
    $display("[TB] restart after reset, write/read with random corruption");
    applyStimulus(1'b1, -1, $urandom_range(1, 4), 0, -1);
    $display("[TB] write/read pass after corrupted one");
    applyStimulus(1'b1, -1, 0, 0, -1);
    $display("[TB] address wrap instance");
    wrapCheck();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ddr2_traffic_gen.md
# ddr2_traffic_gen

Synthesizable traffic generator and checker that drives the user-side write and read request ports of the AXI masters in front of `ddr2_ctrl`. It issues a programmable number of fixed-length bursts at incrementing addresses, with a deterministic data pattern. In verify mode it reads the same region back and compares each beat against the regenerated pattern. It replaces ad-hoc bench stimulus and is also instantiated on hardware for board bring-up.

## Interface
- `ADDR_WIDTH`, 26: width of the user address.
- `DATA_WIDTH`, 32: user data width, equal to two DQ words.
- `BURST_LEN`, 16: beats per burst, driven on `wr_len` and `rd_len`. Range 1..255.
- `NUM_BURSTS`, 4: bursts per pass. Must be at least 1.
- `GAP_CYCLES`, 80: idle cycles before each request.
- `BASE_ADDR`, 0: first burst address.
- `clk` in 1: only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `init_end` in 1: DDR2 initialisation complete.
- `start` in 1: single-cycle pulse that begins a pass.
- `mode` in 1: 0 = write-only, 1 = write then read-verify. Sampled on `start`.
- `busy` out 1: high while a pass runs.
- `done` out 1: one-cycle pulse when a pass ends.
- `pass` out 1: sticky; high when the last verify pass had `err_cnt == 0`.
- `err_cnt` out 16: number of mismatches, saturating.
- `wr_trig` out 1, `wr_len` out 8, `wr_addr` out ADDR_WIDTH, `wr_data` out DATA_WIDTH: write request.
- `wr_ready` in 1, `wr_data_en` in 1, `wr_done` in 1: write responses.
- `rd_trig` out 1, `rd_len` out 8, `rd_addr` out ADDR_WIDTH: read request.
- `rd_ready` in 1, `rd_data_en` in 1, `rd_data` in DATA_WIDTH, `rd_done` in 1: read responses.

## Operation
States:
- IDLE → WR_GAP → WR_REQ → WR_XFER → (next burst: WR_GAP | mode 1: RD_GAP | DONE).
- RD_GAP → RD_REQ → RD_XFER → (next burst: RD_GAP | DONE).
- DONE → IDLE.

Start and request rules:
- `start` is accepted only in IDLE with `init_end == 1`. Otherwise it is ignored.
- On acceptance: `err_cnt` is cleared, `pass` is cleared, and the burst counter, address and pattern generator are reloaded.
- `*_GAP` holds for GAP_CYCLES cycles. With GAP_CYCLES = 0 it lasts one cycle.
- `*_REQ` asserts `*_trig` and holds it until `*_trig && *_ready` in the same cycle. That cycle is the accept, after which the FSM moves to `*_XFER`.
- `*_XFER` ends on `*_done`.

Data and addressing:
- `wr_data` presents the current pattern word. Each `wr_data_en` advances the pattern one step, and the new value is visible the next cycle.
- The address increments by `2*BURST_LEN` on each `*_done`, modulo 2^ADDR_WIDTH (wrap permitted).
- At the write→read switch, the read address and the expected-pattern generator restart from BASE_ADDR and the seed.

Checking:
- On each `rd_data_en`, `rd_data` is compared with the expected word, and then the expected word advances.
- Each mismatch adds 1 to `err_cnt`.
- A beat count not equal to BURST_LEN at `*_done` adds 1 to `err_cnt`. Extra beats are also compared.
- `err_cnt` saturates at 16'hFFFF.

Completion:
- DONE pulses `done`.
- In mode 1, DONE also sets `pass = (err_cnt == 0)`.
- In mode 0, `pass` stays 0.

Simultaneous and unexpected events:
- `wr_data_en` in the same cycle as `wr_done` counts as a beat.
- `*_done` arriving outside `*_XFER` is ignored.
- An `init_end` drop while busy does not abort the pass.

## Timing
- Reset values:
  - `busy`, `done`, `pass`, `wr_trig`, `rd_trig` = 0.
  - `err_cnt` = 0.
  - `wr_addr` = `rd_addr` = BASE_ADDR.
  - `wr_data` = seed (1).
  - `wr_len` = `rd_len` = BURST_LEN (constant).
- `busy` rises the cycle after `start` is accepted and falls together with the `done` pulse.
- First `wr_trig` rises GAP_CYCLES+1 cycles after `start` is accepted.
- All outputs are registered. There is no combinational path from any input to any output.
- Asserting `rst_n` low mid-pass returns every output to its reset value immediately (asynchronously). The sequence restarts only on a new `start`.

## Configuration
- `DDR2_TG_PRBS_EN` defined: the pattern is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, seed 32'h1. It is replicated or truncated to DATA_WIDTH.
- Not defined: the pattern is an incrementing counter starting at 1, +1 per beat.

## Structure
- Package `ddr2_tg_pkg` holds:
  - the state enum;
  - the mode constants `TG_MODE_WR`, `TG_MODE_WRRD`;
  - the seed and LFSR tap constants.
- Sub-module `ddr2_tg_pattern` (load, advance, word out) owns the pattern and the macro switch. It is instantiated twice: write source and read expected.

## Test plan
1. Mode 0, BURST_LEN=16, NUM_BURSTS=4, GAP=80 → 4 accepted `wr_trig` at addresses 0, 32, 64, 96; 64 beats with data 1..64; one `done` pulse; `pass` = 0.
2. Mode 1, clean memory model → 4 writes then 4 reads from address 0; `err_cnt` = 0; `pass` = 1.
3. Mode 1, bench flips bit 0 of read beat 5 of burst 2 → `err_cnt` = 1; `pass` = 0.
4. `wr_ready` held low for 200 cycles → `wr_trig` stays high throughout and drops in the cycle after the accept.
5. BASE_ADDR = 2^26−32, NUM_BURSTS=2 → second address is 0 (wrap).
6. `rst_n` low during burst 3 → all outputs at reset values; `start` with `init_end`=0 is ignored; a later `start` restarts at BASE_ADDR with seed data.
